// File: rtl/link_controller.sv
// Two-board link sequencer: framed TX of local flags, framed RX of peer flags, timeout/error supervision.
// Define LINK_LOOPBACK_EN to feed the RX path from the internal tx instead of the rx port.
module link_controller #(
    parameter int CLK_DIV        = 100,
    parameter int TIMEOUT_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_connect,
    input  logic       send_start,
    input  logic       send_game_finish,
    input  logic       rx,
    output logic       tx,
    output logic       receive_connect,
    output logic       receive_start,
    output logic       receive_game_finish,
    output logic       link_up,
    output logic [7:0] frame_err_cnt
);
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int TMO_LIMIT = TIMEOUT_FRAMES * 8 * CLK_DIV;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic [1:0] {TIDLE, TBIT, TGAP} tx_state_e;
    typedef enum logic [2:0] {RIDLE, RSTART, RDATA, RPAR, RSTOP} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [5:0]       tx_frame_q, tx_frame_d;
    logic [5:0]       new_frame;

    assign new_frame = {1'b1, ^{send_game_finish, send_start, send_connect},
                        send_game_finish, send_start, send_connect, 1'b0};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        case (tx_state_q)
            TIDLE: begin
                tx_state_d = TBIT;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_frame_d = new_frame;
            end
            TBIT: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd5) begin
                        tx_state_d = TGAP;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TGAP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd1) begin
                        // flags are sampled only here, so mid-frame changes wait a frame
                        tx_state_d = TBIT;
                        tx_bit_d   = '0;
                        tx_frame_d = new_frame;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TIDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= 6'h3F;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
        end
    end

    // Decoded from state so an async reset forces the line idle immediately.
    assign tx = (tx_state_q == TBIT) ? tx_frame_q[tx_bit_q] : 1'b1;

    logic rx_src;
`ifdef LINK_LOOPBACK_EN
    assign rx_src = tx;
`else
    assign rx_src = rx;
`endif

    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [1:0]       rx_bit_q, rx_bit_d;
    logic [2:0]       rx_data_q, rx_data_d;
    logic             rx_par_q, rx_par_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             frame_ok, frame_bad;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (rx_state_q)
            RIDLE: begin
                // edge-triggered, so a stuck-low line yields a single error
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RSTART;
                    rx_cnt_d   = '0;
                end
            end
            RSTART: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RIDLE : RDATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RDATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d            = '0;
                    rx_data_d[rx_bit_q] = rx_s2_q;
                    if (rx_bit_q == 2'd2) rx_state_d = RPAR;
                    else                  rx_bit_d   = rx_bit_q + 2'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RPAR: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = RSTOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RSTOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RIDLE;
                    if (rx_s2_q && (rx_par_q == ^rx_data_q)) frame_ok  = 1'b1;
                    else                                     frame_bad = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RIDLE;
        endcase
    end

    logic [2:0]       recv_q, recv_d;
    logic             link_q, link_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       err_q, err_d;

    always_comb begin
        recv_d = recv_q;
        link_d = link_q;
        tmo_d  = tmo_q;
        err_d  = err_q;
        // a valid frame takes priority over a simultaneous expiry
        if (frame_ok) begin
            recv_d = rx_data_q;
            link_d = 1'b1;
            tmo_d  = '0;
        end else if (link_q) begin
            if (tmo_q == TMO_LAST) begin
                link_d = 1'b0;
                recv_d = '0;
                tmo_d  = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        if (frame_bad && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RIDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
            recv_q     <= '0;
            link_q     <= 1'b0;
            tmo_q      <= '0;
            err_q      <= '0;
        end else begin
            rx_s1_q    <= rx_src;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_par_q   <= rx_par_d;
            recv_q     <= recv_d;
            link_q     <= link_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign receive_connect     = recv_q[0];
    assign receive_start       = recv_q[1];
    assign receive_game_finish = recv_q[2];
    assign link_up             = link_q;
    assign frame_err_cnt       = err_q;
endmodule
